hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Stall/bubble source for the 5-stage MIPS pipeline; drives the hold inputs of PC and F/D and the bubble insert at the D/E boundary.
- Decodes the instruction in D and keeps its own shadow scoreboard of the E and M stages (destination register, Tnew, mult/div flag).
- Owns the multiply/divide busy countdown.
- Sits beside the D-stage decoder; consumes only Instr_D and A3_D.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu enters E
- DIV_CYCLES, 10, busy cycles after div/divu enters E

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Instr_D  in  32  instruction currently in D
- A3_D  in  5  destination register of Instr_D as resolved by the decoder (0 = no write)
- stall_PC  out  1  hold PC
- stall_FD  out  1  hold F/D register
- bubble_DE  out  1  load a nop (all-zero) into D/E this cycle
- md_busy  out  1  mult/div unit busy, for debug and the MDU

Behaviour:
- Supported set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, nop.
- Any other encoding is treated as nop: no use, no write.
- Tuse for rs:
  - beq, jr: 0
  - addu, subu, ori, lw, sw, mult*, div*, mthi, mtlo: 1
- Tuse for rt:
  - beq: 0
  - addu, subu, mult*, div*: 1
  - sw: 2
  - otherwise unused
- Tnew as decoded in D:
  - jal: 0
  - addu, subu, ori, lui, mfhi, mflo: 1
  - lw: 2
  - A3_D = 0: no write
- Shadow state: A3_E, Tnew_E, md_E, A3_M, Tnew_M. All are 0 after reset.
- Each clock with no stall:
  - E shadow <= D decode.
  - M shadow <= E shadow, with Tnew_M = max(Tnew_E - 1, 0).
- Each clock with stall:
  - E shadow <= bubble (A3 = 0, Tnew = 0, md = 0).
  - M shadow still advances from E.
- Data stall, evaluated combinationally from the current state and Instr_D. For each used source register r != 0:
  - (r == A3_E and Tnew_E > Tuse), or
  - (r == A3_M and Tnew_M > Tuse).
- A match in E takes priority. The register $0 never stalls.
- MDU countdown:
  - When md_E = 1, cnt loads MULT_CYCLES or DIV_CYCLES. The kind is latched with md_E.
  - Otherwise cnt decrements while nonzero.
  - md_busy = md_E | (cnt != 0).
- MDU stall: Instr_D is any of mult*, div*, mfhi, mflo, mthi, mtlo and md_busy = 1.
- stall = data stall | MDU stall. stall_PC = stall_FD = bubble_DE = stall.
- Latency: stall is asserted in the same cycle as the hazard. It drops in the cycle the hazard clears (cnt reaching 0, or the producer advancing past the condition).
- Simultaneous data and MDU stall: a single stall. Both conditions are re-evaluated every cycle.
- Reset:
  - While reset = 1, all outputs are 0.
  - The shadow state and cnt clear on the edge, so a reset mid-divide aborts busy immediately.
- cnt width is clog2(max(MULT_CYCLES, DIV_CYCLES) + 1). No wrap: it decrements only while nonzero.

Optional Feature:
- Macro HAZARD_STALL_STAT_EN.
- When defined, adds output stall_cnt (32 bits):
  - increments on every clock where stall = 1 and reset = 0;
  - saturates at 32'hFFFFFFFF;
  - cleared by reset.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- lw $1,0($0) decoded, next cycle addu $2,$1,$3 in D:
  - stall = 1 for exactly 1 cycle (E match, Tnew_E = 2 > 1);
  - then 0 (M match, Tnew_M = 1, not > 1);
  - bubble_DE pulses once.
- lw $1 followed by beq $1,$0:
  - stall = 1 for 2 cycles (E: 2 > 0, then M: 1 > 0);
  - then 0.
- addu $0,$1,$2 followed by beq $0,$0, and lw $1 followed by sw $1,0($2):
  - stall = 0 in both cases ($0 never stalls; sw rt Tuse = 2).
- div $4,$5 advances to E, then mflo $6 held in D:
  - md_busy = 1 for 1 + 10 cycles;
  - stall = 1 each of those cycles, dropping when cnt = 0;
  - with MULT_CYCLES = 5 and mult instead: 6 cycles.
- reset asserted 3 cycles into a div with mfhi in D:
  - outputs 0 during reset;
  - after release with Instr_D = mfhi, md_busy = 0 and stall = 0.
- HAZARD_STALL_STAT_EN defined, running the first scenario then the fourth (div case):
  - stall_cnt = 12;
  - reset returns it to 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : D-stage stall/bubble source for the 5-stage MIPS pipeline, with
//            a shadow E/M scoreboard and the mult/div busy countdown.
//            Optional stall counter output under HAZARD_STALL_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  input  logic [4:0]  A3_D,
  output logic        stall_PC,
  output logic        stall_FD,
  output logic        bubble_DE,
  output logic        md_busy
`ifdef HAZARD_STALL_STAT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_instr_bits;

  assign opcode            = Instr_D[31:26];
  assign funct             = Instr_D[5:0];
  assign rs                = Instr_D[25:21];
  assign rt                = Instr_D[20:16];
  assign unused_instr_bits = ^Instr_D[15:6];

  // D-stage decode
  logic       is_r, is_addsub, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_jr;
  logic       is_mult, is_div, is_mfhilo, is_mthilo, alu_write;
  logic       use_rs, use_rt, writes_d, md_d, hilo_user;
  logic [1:0] tuse_rs, tuse_rt, tnew_d;

  always_comb begin
    is_r      = (opcode == OP_RTYPE);
    is_addsub = is_r && ((funct == FN_ADDU) || (funct == FN_SUBU));
    is_jr     = is_r && (funct == FN_JR);
    is_mult   = is_r && ((funct == FN_MULT) || (funct == FN_MULTU));
    is_div    = is_r && ((funct == FN_DIV) || (funct == FN_DIVU));
    is_mfhilo = is_r && ((funct == FN_MFHI) || (funct == FN_MFLO));
    is_mthilo = is_r && ((funct == FN_MTHI) || (funct == FN_MTLO));
    is_ori    = (opcode == OP_ORI);
    is_lui    = (opcode == OP_LUI);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_beq    = (opcode == OP_BEQ);
    is_jal    = (opcode == OP_JAL);

    use_rs    = is_beq | is_jr | is_addsub | is_ori | is_lw | is_sw |
                is_mult | is_div | is_mthilo;
    tuse_rs   = (is_beq | is_jr) ? 2'd0 : 2'd1;
    use_rt    = is_beq | is_addsub | is_mult | is_div | is_sw;
    tuse_rt   = is_beq ? 2'd0 : (is_sw ? 2'd2 : 2'd1);

    alu_write = is_addsub | is_ori | is_lui | is_mfhilo;
    writes_d  = (is_jal | alu_write | is_lw) && (A3_D != 5'd0);
    tnew_d    = is_lw ? 2'd2 : (alu_write ? 2'd1 : 2'd0);

    md_d      = is_mult | is_div;
    hilo_user = md_d | is_mfhilo | is_mthilo;
  end

  // Shadow scoreboard of the E and M stages
  logic [4:0]       a3_e, a3_m;
  logic [1:0]       tnew_e, tnew_m;
  logic             md_e, div_e;
  logic [CNT_W-1:0] cnt;

  // The youngest producer (E) wins: when it matches, its value is forwarded
  // and any older writer in M is irrelevant.
  function automatic logic src_stall(
    input logic       used,
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] a3e,
    input logic [1:0] tne,
    input logic [4:0] a3m,
    input logic [1:0] tnm
  );
    logic hit;
    hit = 1'b0;
    if (used && (r != 5'd0)) begin
      if (r == a3e) hit = (tne > tuse);
      else          hit = (r == a3m) && (tnm > tuse);
    end
    return hit;
  endfunction

  logic busy_raw, data_stall, mdu_stall, stall;

  always_comb begin
    busy_raw   = md_e | (cnt != '0);
    data_stall = src_stall(use_rs, rs, tuse_rs, a3_e, tnew_e, a3_m, tnew_m) |
                 src_stall(use_rt, rt, tuse_rt, a3_e, tnew_e, a3_m, tnew_m);
    mdu_stall  = hilo_user & busy_raw;
    stall      = (data_stall | mdu_stall) & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_e   <= 5'd0;
      tnew_e <= 2'd0;
      md_e   <= 1'b0;
      div_e  <= 1'b0;
      a3_m   <= 5'd0;
      tnew_m <= 2'd0;
    end else begin
      a3_m   <= a3_e;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      if (stall) begin
        a3_e   <= 5'd0;
        tnew_e <= 2'd0;
        md_e   <= 1'b0;
        div_e  <= 1'b0;
      end else begin
        a3_e   <= writes_d ? A3_D : 5'd0;
        tnew_e <= writes_d ? tnew_d : 2'd0;
        md_e   <= md_d;
        div_e  <= is_div;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (md_e) begin
      cnt <= div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_STALL_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign stall_PC  = stall;
  assign stall_FD  = stall;
  assign bubble_DE = stall;
  assign md_busy   = busy_raw & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// Testbench for hazard_stall_ctrl: directed scenarios with literal expectations
// plus randomized instruction streams checked against a cycle-timestamp model.
module tb_hazard_stall_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr_D = 32'd0;
  logic [4:0]  A3_D = 5'd0;
  logic        stall_PC, stall_FD, bubble_DE, md_busy;
`ifdef HAZARD_STALL_STAT_EN
  logic [31:0] stall_cnt;
  longint      model_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .A3_D(A3_D),
    .stall_PC(stall_PC), .stall_FD(stall_FD), .bubble_DE(bubble_DE), .md_busy(md_busy)
`ifdef HAZARD_STALL_STAT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef enum int {M_NOP, M_ADDU, M_SUBU, M_ORI, M_LUI, M_LW, M_SW, M_BEQ, M_J, M_JAL, M_JR,
                    M_MULT, M_MULTU, M_DIV, M_DIVU, M_MFHI, M_MFLO, M_MTHI, M_MTLO} mnem_t;

  function automatic mnem_t classify(input logic [31:0] ins);
    mnem_t m;
    m = M_NOP;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h21: m = M_ADDU;  6'h23: m = M_SUBU;  6'h08: m = M_JR;
        6'h18: m = M_MULT;  6'h19: m = M_MULTU; 6'h1a: m = M_DIV;  6'h1b: m = M_DIVU;
        6'h10: m = M_MFHI;  6'h12: m = M_MFLO;  6'h11: m = M_MTHI; 6'h13: m = M_MTLO;
        default: m = M_NOP;
      endcase
      6'h0d: m = M_ORI;  6'h0f: m = M_LUI; 6'h23: m = M_LW; 6'h2b: m = M_SW;
      6'h04: m = M_BEQ;  6'h02: m = M_J;   6'h03: m = M_JAL;
      default: m = M_NOP;
    endcase
    return m;
  endfunction

  // -1 means the field is not read
  function automatic int tuse_rs_of(input mnem_t m);
    case (m)
      M_BEQ, M_JR: return 0;
      M_ADDU, M_SUBU, M_ORI, M_LW, M_SW, M_MULT, M_MULTU, M_DIV, M_DIVU, M_MTHI, M_MTLO: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int tuse_rt_of(input mnem_t m);
    case (m)
      M_BEQ: return 0;
      M_ADDU, M_SUBU, M_MULT, M_MULTU, M_DIV, M_DIVU: return 1;
      M_SW: return 2;
      default: return -1;
    endcase
  endfunction

  // -1 means no register write
  function automatic int tnew_of(input mnem_t m);
    case (m)
      M_JAL: return 0;
      M_ADDU, M_SUBU, M_ORI, M_LUI, M_MFHI, M_MFLO: return 1;
      M_LW: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_md(input mnem_t m);
    return (m == M_MULT) || (m == M_MULTU) || (m == M_DIV) || (m == M_DIVU);
  endfunction

  function automatic bit uses_hilo(input mnem_t m);
    return is_md(m) || (m == M_MFHI) || (m == M_MFLO) || (m == M_MTHI) || (m == M_MTLO);
  endfunction

  // Producers carry the absolute cycle their result becomes available
  int cyc = 0;
  int e_dest = 0, e_ready = 0, m_dest = 0, m_ready = 0;
  int busy_until = -1;
  bit model_ready = 1'b0;
  bit last_stall = 1'b0;

  function automatic bit src_stall(input int r, input int tuse);
    int rem;
    if (tuse < 0 || r == 0) return 1'b0;
    if (r == e_dest) begin
      rem = (e_ready > cyc) ? e_ready - cyc : 0;
      return rem > tuse;
    end
    if (r == m_dest) begin
      rem = (m_ready > cyc) ? m_ready - cyc : 0;
      return rem > tuse;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_busy();
    return !reset && (cyc <= busy_until);
  endfunction

  function automatic bit exp_stall();
    mnem_t m;
    bit data;
    m = classify(Instr_D);
    if (reset) return 1'b0;
    data = src_stall(int'(Instr_D[25:21]), tuse_rs_of(m)) |
           src_stall(int'(Instr_D[20:16]), tuse_rt_of(m));
    return data || (uses_hilo(m) && cyc <= busy_until);
  endfunction

  always @(posedge clk) begin
    bit    st;
    mnem_t m;
    int    tn;
    st = exp_stall();
    m  = classify(Instr_D);
    if (reset) begin
      e_dest = 0; e_ready = 0; m_dest = 0; m_ready = 0; busy_until = -1;
`ifdef HAZARD_STALL_STAT_EN
      model_cnt = 0;
`endif
      model_ready = 1'b1;
    end else begin
`ifdef HAZARD_STALL_STAT_EN
      if (st && model_cnt < 64'hFFFF_FFFF) model_cnt = model_cnt + 1;
`endif
      m_dest = e_dest; m_ready = e_ready;
      if (st) begin
        e_dest = 0; e_ready = 0;
      end else begin
        tn = tnew_of(m);
        if (tn >= 0 && A3_D != 5'd0) begin
          e_dest = int'(A3_D); e_ready = cyc + 1 + tn;
        end else begin
          e_dest = 0; e_ready = 0;
        end
        if (is_md(m))
          busy_until = cyc + 1 + ((m == M_DIV || m == M_DIVU) ? DIV_CYCLES : MULT_CYCLES);
      end
    end
    last_stall = st;
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit es, eb;
    if (model_ready) begin
      es = exp_stall();
      eb = exp_busy();
      check("stall_PC", {31'd0, stall_PC}, {31'd0, es});
      check("stall_FD", {31'd0, stall_FD}, {31'd0, es});
      check("bubble_DE", {31'd0, bubble_DE}, {31'd0, es});
      check("md_busy", {31'd0, md_busy}, {31'd0, eb});
`ifdef HAZARD_STALL_STAT_EN
      check("stall_cnt", stall_cnt, model_cnt[31:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] LW1     = 32'h8C01_0000;  // lw $1,0($0)
  localparam logic [31:0] ADDU213 = 32'h0023_1021;  // addu $2,$1,$3
  localparam logic [31:0] BEQ10   = 32'h1020_0000;  // beq $1,$0
  localparam logic [31:0] ADDU012 = 32'h0022_0021;  // addu $0,$1,$2
  localparam logic [31:0] BEQ00   = 32'h1000_0000;  // beq $0,$0
  localparam logic [31:0] SW12    = 32'hAC41_0000;  // sw $1,0($2)
  localparam logic [31:0] DIV45   = 32'h0085_001A;  // div $4,$5
  localparam logic [31:0] MULT45  = 32'h0085_0018;  // mult $4,$5
  localparam logic [31:0] MFLO6   = 32'h0000_3012;  // mflo $6
  localparam logic [31:0] MFHI6   = 32'h0000_3010;  // mfhi $6

  task automatic put(input logic [31:0] ins, input logic [4:0] a3);
    @(posedge clk); #1;
    Instr_D = ins; A3_D = a3;
  endtask

  task automatic hold();
    @(posedge clk); #1;
  endtask

  task automatic expect_lit(input string name, input bit es, input bit eb);
    @(negedge clk);
    check({name, "_stall"}, {31'd0, stall_PC}, {31'd0, es});
    check({name, "_busy"}, {31'd0, md_busy}, {31'd0, eb});
  endtask

  task automatic gen(output logic [31:0] ins, output logic [4:0] a3);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k;
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    k = $urandom_range(0, 20);
    a3 = 5'd0;
    case (k)
      0:  begin ins = {6'h00, rs, rt, rd, 5'h0, 6'h21}; a3 = rd; end
      1:  begin ins = {6'h00, rs, rt, rd, 5'h0, 6'h23}; a3 = rd; end
      2:  begin ins = {6'h0d, rs, rt, imm}; a3 = rt; end
      3:  begin ins = {6'h0f, 5'h0, rt, imm}; a3 = rt; end
      4:  begin ins = {6'h23, rs, rt, imm}; a3 = rt; end
      5:  ins = {6'h2b, rs, rt, imm};
      6:  ins = {6'h04, rs, rt, imm};
      7:  ins = {6'h02, 26'($urandom)};
      8:  begin ins = {6'h03, 26'($urandom)}; a3 = 5'd31; end
      9:  ins = {6'h00, rs, 15'h0, 6'h08};
      10: ins = {6'h00, rs, rt, 10'h0, 6'h18};
      11: ins = {6'h00, rs, rt, 10'h0, 6'h19};
      12, 20: ins = {6'h00, rs, rt, 10'h0, 6'h1a};
      13: ins = {6'h00, rs, rt, 10'h0, 6'h1b};
      14: begin ins = {6'h00, 10'h0, rd, 5'h0, 6'h10}; a3 = rd; end
      15: begin ins = {6'h00, 10'h0, rd, 5'h0, 6'h12}; a3 = rd; end
      16: ins = {6'h00, rs, 15'h0, 6'h11};
      17: ins = {6'h00, rs, 15'h0, 6'h13};
      18: ins = 32'd0;
      default: ins = $urandom;
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  a3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    expect_lit("reset", 1'b0, 1'b0);
    #1 reset = 1'b0;
    put(NOP, 5'd0);         expect_lit("idle", 1'b0, 1'b0);

    // load-use into addu: one bubble
    put(LW1, 5'd1);         expect_lit("s1_lw", 1'b0, 1'b0);
    put(ADDU213, 5'd2);     expect_lit("s1_e", 1'b1, 1'b0);
    hold();                 expect_lit("s1_m", 1'b0, 1'b0);
    put(NOP, 5'd0);
    put(NOP, 5'd0);

    // div then mflo waiting on the divider
    put(DIV45, 5'd0);       expect_lit("div_d", 1'b0, 1'b0);
    put(MFLO6, 5'd6);
    for (int i = 0; i < 1 + DIV_CYCLES; i++) begin
      expect_lit("div_wait", 1'b1, 1'b1);
      hold();
    end
    expect_lit("div_done", 1'b0, 1'b0);
`ifdef HAZARD_STALL_STAT_EN
    check("stat_after_div", stall_cnt, 32'd12);
`endif
    put(NOP, 5'd0);
    put(NOP, 5'd0);

    // load into beq: two bubbles
    put(LW1, 5'd1);         expect_lit("s2_lw", 1'b0, 1'b0);
    put(BEQ10, 5'd0);       expect_lit("s2_e", 1'b1, 1'b0);
    hold();                 expect_lit("s2_m", 1'b1, 1'b0);
    hold();                 expect_lit("s2_clr", 1'b0, 1'b0);
    put(NOP, 5'd0);

    // $0 and store-data never stall
    put(ADDU012, 5'd0);     expect_lit("s3_a", 1'b0, 1'b0);
    put(BEQ00, 5'd0);       expect_lit("s3_beq0", 1'b0, 1'b0);
    put(LW1, 5'd1);         expect_lit("s3_lw", 1'b0, 1'b0);
    put(SW12, 5'd0);        expect_lit("s3_sw", 1'b0, 1'b0);
    put(NOP, 5'd0);
    put(NOP, 5'd0);

    // mult latency
    put(MULT45, 5'd0);      expect_lit("mult_d", 1'b0, 1'b0);
    put(MFLO6, 5'd6);
    for (int i = 0; i < 1 + MULT_CYCLES; i++) begin
      expect_lit("mult_wait", 1'b1, 1'b1);
      hold();
    end
    expect_lit("mult_done", 1'b0, 1'b0);
    put(NOP, 5'd0);
    put(NOP, 5'd0);

    // reset in the middle of a divide
    put(DIV45, 5'd0);       expect_lit("rd_div", 1'b0, 1'b0);
    put(MFHI6, 5'd6);       expect_lit("rd_w1", 1'b1, 1'b1);
    hold();                 expect_lit("rd_w2", 1'b1, 1'b1);
    hold();                 expect_lit("rd_w3", 1'b1, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    expect_lit("rd_in_reset", 1'b0, 1'b0);
    hold();                 expect_lit("rd_in_reset2", 1'b0, 1'b0);
`ifdef HAZARD_STALL_STAT_EN
    check("stat_reset", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    expect_lit("rd_after", 1'b0, 1'b0);

    // randomized traffic, instructions held while stalled
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      if (!last_stall) begin
        gen(ins, a3);
        Instr_D = ins; A3_D = a3;
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
